p4_iter_shifter: RTL and testbench
==================================

Name: p4_iter_shifter

Overview:
- Parametrised, multi-cycle successor to the datapath's single-bit shifter.
- Accepts an operand, mode and shift amount with a start/done handshake.
- Shifts iteratively by up to STEP bits per clock, and reports the result plus the last bit shifted out (carry).
- Sits beside the ALU in the datapath. The controller FSM starts it and waits on done.

Parameters:
WIDTH, 16, operand/result width in bits (>= 2)
AMT_W, 5, width of the shift-amount port; amounts up to 2^AMT_W-1 are legal, including amounts >= WIDTH
STEP, 1, maximum bits shifted per clock (1..WIDTH)

Ports:
clk    input   1      rising-edge clock
reset  input   1      synchronous, active-high reset
start  input   1      request; accepted only when busy==0
in     input   WIDTH  operand, sampled on the accepting edge
mode   input   3      000 pass, 001 LSL, 010 LSR, 011 ASR, 100 ROR, 101-111 pass
amt    input   AMT_W  shift amount, sampled on the accepting edge
sout   output  WIDTH  result register
carry  output  1      last bit shifted/rotated out
busy   output  1      high while in SHIFT
done   output  1      one-cycle pulse, result valid

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: on a reset edge, state=IDLE, sout=0, carry=0, busy=0, done=0. Reset wins over start and aborts any operation in flight; no done pulse is produced.
- States: IDLE, SHIFT, DONE. busy = (state==SHIFT). done = (state==DONE).
- Start acceptance: start is accepted on an edge where state is IDLE or DONE, which allows back-to-back operations. On the accepting edge:
  - sout<=in, carry<=0, rem<=amt, mode is latched.
  - If amt==0 or the mode is a pass code, next state is DONE.
  - Otherwise next state is SHIFT.
- start ignored while busy: start while state==SHIFT is ignored and not queued. Inputs are not re-sampled.
- Each SHIFT edge:
  - k = min(STEP, rem).
  - sout is shifted by k using the latched mode; rem<=rem-k.
  - When rem-k==0, next state is DONE; otherwise stay in SHIFT.
- Shift semantics: the result must equal k repeated 1-bit operations.
  - LSL: zero fill; carry = last bit leaving bit WIDTH-1.
  - LSR: zero fill; carry = last bit leaving bit 0.
  - ASR: sign fill, MSB copied; carry = last bit leaving bit 0.
  - ROR: bit 0 wraps to bit WIDTH-1; carry = last bit wrapped (the new MSB).
- Amounts >= WIDTH are handled naturally by iteration:
  - LSL/LSR give 0, with carry=0 once amt>WIDTH.
  - ASR gives all sign bits, with carry=sign.
  - ROR is effectively modulo WIDTH.
- DONE state: lasts exactly one cycle and then returns to IDLE unless a new start is accepted.
- Result hold: sout and carry hold until the next accepting edge or reset.
- Latency: done is high in the cycle following the edge numbered 1 + ceil(amt/STEP), counting the accepting edge as edge 1. amt==0 or pass gives 1 edge.
- Width rules: rem is AMT_W bits and never underflows. No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. Basic LSL: WIDTH=16, STEP=1, mode=001, in=16'hF00F, amt=4 -> busy for 4 cycles; done pulses after edge 5; sout=16'h00F0, carry=1.
2. ASR: mode=011, in=16'h8001, amt=3 -> sout=16'hF000, carry=0. Also in=16'h8000, amt=20 -> sout=16'hFFFF, carry=1.
3. ROR past WIDTH: mode=100, in=16'h0001, amt=17 -> 17 SHIFT cycles; sout=16'h8000, carry=1.
4. Zero-amount and pass cases:
   - mode=010, amt=0, in=16'h1234 -> done after edge 1; busy never high; sout=16'h1234, carry=0.
   - mode=111, amt=9 -> same timing, sout=in.
5. Protocol: start re-asserted with in=16'hFFFF mid-shift -> ignored, original result returned. A reset mid-SHIFT -> next cycle sout=0, busy=0, and no done pulse. start held high through DONE -> the new operation is accepted with no idle gap.
6. STEP=4, mode=010, in=16'hABCD, amt=6 -> two SHIFT cycles (4 then 2 bits); done after edge 3; sout=16'h02AF, carry=0.

Source files
------------

// File: rtl/p4_iter_shifter.sv
// Iterative multi-cycle shifter: LSL/LSR/ASR/ROR by up to STEP bits per clock,
// with a start/done handshake and a carry holding the last bit shifted out.
module p4_iter_shifter #(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned AMT_W = 5,
   parameter int unsigned STEP  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] in,
   input  logic [2:0]       mode,
   input  logic [AMT_W-1:0] amt,
   output logic [WIDTH-1:0] sout,
   output logic             carry,
   output logic             busy,
   output logic             done
);

   localparam logic [2:0] ModeLsl = 3'b001;
   localparam logic [2:0] ModeLsr = 3'b010;
   localparam logic [2:0] ModeAsr = 3'b011;
   localparam logic [2:0] ModeRor = 3'b100;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   sout_q, sout_d;
   logic               carry_q, carry_d;
   logic [AMT_W-1:0]   rem_q, rem_d;
   logic [2:0]         mode_q, mode_d;

   logic               accept;
   logic               shift_mode;
   logic [AMT_W-1:0]   k;
   logic [31:0]        rem_ext;
   logic [WIDTH-1:0]   sh_v;
   logic               sh_c;

   // Unrolled chain of STEP single-bit stages; stage i is active only while i < rem,
   // which makes the step size min(STEP, rem) without a separate barrel shifter.
   always_comb begin
      sh_v    = sout_q;
      sh_c    = carry_q;
      rem_ext = 32'(rem_q);
      for (int unsigned i = 0; i < STEP; i++) begin
         if (i < rem_ext) begin
            case (mode_q)
               ModeLsl: begin
                  sh_c = sh_v[WIDTH-1];
                  sh_v = {sh_v[WIDTH-2:0], 1'b0};
               end
               ModeLsr: begin
                  sh_c = sh_v[0];
                  sh_v = {1'b0, sh_v[WIDTH-1:1]};
               end
               ModeAsr: begin
                  sh_c = sh_v[0];
                  sh_v = {sh_v[WIDTH-1], sh_v[WIDTH-1:1]};
               end
               ModeRor: begin
                  sh_c = sh_v[0];
                  sh_v = {sh_v[0], sh_v[WIDTH-1:1]};
               end
               default: ;
            endcase
         end
      end
      k = (rem_ext < STEP) ? rem_q : AMT_W'(STEP);
   end

   assign shift_mode = (mode == ModeLsl) || (mode == ModeLsr) ||
                       (mode == ModeAsr) || (mode == ModeRor);
   assign accept     = start && (state_q != StShift);

   always_comb begin
      state_d = state_q;
      sout_d  = sout_q;
      carry_d = carry_q;
      rem_d   = rem_q;
      mode_d  = mode_q;

      case (state_q)
         StShift: begin
            sout_d  = sh_v;
            carry_d = sh_c;
            rem_d   = rem_q - k;
            state_d = (rem_q == k) ? StDone : StShift;
         end
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase

      // Accepting from DONE as well as IDLE allows back-to-back operations.
      if (accept) begin
         sout_d  = in;
         carry_d = 1'b0;
         rem_d   = amt;
         mode_d  = mode;
         state_d = ((amt == '0) || !shift_mode) ? StDone : StShift;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         sout_q  <= '0;
         carry_q <= 1'b0;
         rem_q   <= '0;
         mode_q  <= '0;
      end else begin
         state_q <= state_d;
         sout_q  <= sout_d;
         carry_q <= carry_d;
         rem_q   <= rem_d;
         mode_q  <= mode_d;
      end
   end

   assign sout  = sout_q;
   assign carry = carry_q;
   assign busy  = (state_q == StShift);
   assign done  = (state_q == StDone);

endmodule

// File: tb/tb_p4_iter_shifter.sv
// Bench for p4_iter_shifter: one STEP=1 and one STEP=4 instance, scoreboard of
// expected results/latencies popped and compared when done pulses.
module tb_p4_iter_shifter;

   localparam int Timeout = 64;

   logic        clk;
   logic        reset;
   logic        start1, start4;
   logic [15:0] op_in;
   logic [2:0]  op_mode;
   logic [4:0]  op_amt;
   logic [15:0] sout1, sout4;
   logic        carry1, carry4, busy1, busy4, done1, done4;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [15:0] s;
      logic        c;
      int          edges;
      int          busy;
   } exp_t;

   exp_t sb[$];

   p4_iter_shifter #(.WIDTH(16), .AMT_W(5), .STEP(1)) dut1 (
      .clk(clk), .reset(reset), .start(start1), .in(op_in), .mode(op_mode), .amt(op_amt),
      .sout(sout1), .carry(carry1), .busy(busy1), .done(done1)
   );

   p4_iter_shifter #(.WIDTH(16), .AMT_W(5), .STEP(4)) dut4 (
      .clk(clk), .reset(reset), .start(start4), .in(op_in), .mode(op_mode), .amt(op_amt),
      .sout(sout4), .carry(carry4), .busy(busy4), .done(done4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1);
   end

   // Reference: repeated single-bit operations.
   function automatic exp_t model(input bit sel, input logic [15:0] a, input logic [2:0] m,
                                  input logic [4:0] n);
      exp_t e;
      int   step;
      step = sel ? 4 : 1;
      e.s = a;
      e.c = 1'b0;
      if (!(m inside {3'd1, 3'd2, 3'd3, 3'd4}) || n == 0) begin
         e.edges = 1;
         e.busy  = 0;
      end else begin
         for (int i = 0; i < int'(n); i++) begin
            case (m)
               3'd1: begin e.c = e.s[15]; e.s = {e.s[14:0], 1'b0}; end
               3'd2: begin e.c = e.s[0];  e.s = {1'b0, e.s[15:1]}; end
               3'd3: begin e.c = e.s[0];  e.s = {e.s[15], e.s[15:1]}; end
               default: begin e.c = e.s[0]; e.s = {e.s[0], e.s[15:1]}; end
            endcase
         end
         e.busy  = (int'(n) + step - 1) / step;
         e.edges = 1 + e.busy;
      end
      return e;
   endfunction

   // Waits (bounded) for done; edges = -1 on timeout.
   task automatic wait_done(input bit sel, input int edges0, output int edges, output int bcyc);
      edges = edges0;
      bcyc  = 0;
      while (!(sel ? done4 : done1) && edges < Timeout) begin
         if (sel ? busy4 : busy1) bcyc++;
         @(negedge clk);
         edges++;
      end
      if (!(sel ? done4 : done1)) edges = -1;
   endtask

   task automatic run_op(input bit sel, input logic [15:0] a, input logic [2:0] m,
                         input logic [4:0] n, output exp_t got);
      int e, b;
      @(negedge clk);
      op_in = a; op_mode = m; op_amt = n;
      if (sel) start4 = 1'b1; else start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      wait_done(sel, 1, e, b);
      got.s     = sel ? sout4 : sout1;
      got.c     = sel ? carry4 : carry1;
      got.edges = e;
      got.busy  = b;
   endtask

   task automatic test_reset;
      start1 = 1'b1; start4 = 1'b1;
      op_in = 16'hFFFF; op_mode = 3'b001; op_amt = 5'd3;
      reset = 1'b1;
      repeat (3) @(negedge clk);
      start1 = 1'b0; start4 = 1'b0;
      reset = 1'b0;
      tests++; if (sout1 !== 16'h0) begin fails++; $display("FAIL reset_sout1: got %h want 0000", sout1); end
      tests++; if (carry1 !== 1'b0) begin fails++; $display("FAIL reset_carry1: got %b want 0", carry1); end
      tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL reset_busy1: got %b want 0", busy1); end
      tests++; if (done1 !== 1'b0) begin fails++; $display("FAIL reset_done1: got %b want 0", done1); end
      tests++; if ({sout4, carry4, busy4, done4} !== 19'h0) begin
         fails++; $display("FAIL reset_dut4: got %h want 0", {sout4, carry4, busy4, done4});
      end
   endtask

   // Pops the oldest expectation and compares it against an observed result.
   task automatic test_table(input string name, input bit sel, input logic [15:0] a,
                             input logic [2:0] m, input logic [4:0] n,
                             input logic [15:0] ws, input logic wc);
      exp_t got, e;
      e = model(sel, a, m, n);
      e.s = ws;
      e.c = wc;
      sb.push_back(e);
      run_op(sel, a, m, n, got);
      e = sb.pop_front();
      tests++; if (got.s !== e.s) begin fails++; $display("FAIL %s_sout: got %h want %h", name, got.s, e.s); end
      tests++; if (got.c !== e.c) begin fails++; $display("FAIL %s_carry: got %b want %b", name, got.c, e.c); end
      tests++; if (got.edges !== e.edges) begin
         fails++; $display("FAIL %s_latency: got %0d want %0d", name, got.edges, e.edges);
      end
      tests++; if (got.busy !== e.busy) begin
         fails++; $display("FAIL %s_busy_cycles: got %0d want %0d", name, got.busy, e.busy);
      end
   endtask

   task automatic test_lsl;
      test_table("lsl", 1'b0, 16'hF00F, 3'b001, 5'd4, 16'h00F0, 1'b1);
   endtask

   task automatic test_asr;
      test_table("asr3", 1'b0, 16'h8001, 3'b011, 5'd3, 16'hF000, 1'b0);
      test_table("asr20", 1'b0, 16'h8000, 3'b011, 5'd20, 16'hFFFF, 1'b1);
   endtask

   task automatic test_ror;
      test_table("ror17", 1'b0, 16'h0001, 3'b100, 5'd17, 16'h8000, 1'b1);
      test_table("lsl_over", 1'b0, 16'hFFFF, 3'b001, 5'd17, 16'h0000, 1'b0);
   endtask

   task automatic test_pass;
      test_table("zero_amt", 1'b0, 16'h1234, 3'b010, 5'd0, 16'h1234, 1'b0);
      test_table("pass111", 1'b0, 16'h5A5A, 3'b111, 5'd9, 16'h5A5A, 1'b0);
   endtask

   task automatic test_step4;
      test_table("step4", 1'b1, 16'hABCD, 3'b010, 5'd6, 16'h02AF, 1'b0);
   endtask

   task automatic test_ignore_start;
      exp_t got, e;
      int   ed, bc;
      sb.push_back(model(1'b0, 16'h00FF, 3'b001, 5'd6));
      @(negedge clk);
      op_in = 16'h00FF; op_mode = 3'b001; op_amt = 5'd6; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      @(negedge clk);
      op_in = 16'hFFFF; op_mode = 3'b000; op_amt = 5'd0; start1 = 1'b1;
      repeat (2) @(negedge clk);
      start1 = 1'b0;
      wait_done(1'b0, 4, ed, bc);
      e = sb.pop_front();
      tests++; if (sout1 !== e.s) begin fails++; $display("FAIL ignore_sout: got %h want %h", sout1, e.s); end
      tests++; if (carry1 !== e.c) begin fails++; $display("FAIL ignore_carry: got %b want %b", carry1, e.c); end
      tests++; if (ed !== e.edges) begin fails++; $display("FAIL ignore_latency: got %0d want %0d", ed, e.edges); end
   endtask

   task automatic test_reset_abort;
      int seen;
      @(negedge clk);
      op_in = 16'h1357; op_mode = 3'b100; op_amt = 5'd10; start1 = 1'b1;
      @(negedge clk);
      start1 = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tests++; if (sout1 !== 16'h0) begin fails++; $display("FAIL abort_sout: got %h want 0000", sout1); end
      tests++; if (busy1 !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy1); end
      tests++; if (carry1 !== 1'b0) begin fails++; $display("FAIL abort_carry: got %b want 0", carry1); end
      seen = 0;
      repeat (14) begin
         if (done1 !== 1'b0) seen++;
         @(negedge clk);
      end
      tests++; if (seen !== 0) begin fails++; $display("FAIL abort_done: got %0d pulses want 0", seen); end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   ed, bc;
      sb.push_back(model(1'b0, 16'hF000, 3'b010, 5'd3));
      sb.push_back(model(1'b0, 16'h8000, 3'b011, 5'd2));
      @(negedge clk);
      op_in = 16'hF000; op_mode = 3'b010; op_amt = 5'd3; start1 = 1'b1;
      @(negedge clk);
      wait_done(1'b0, 1, ed, bc);
      e = sb.pop_front();
      tests++; if (sout1 !== e.s || carry1 !== e.c) begin
         fails++; $display("FAIL b2b_first: got %h/%b want %h/%b", sout1, carry1, e.s, e.c);
      end
      op_in = 16'h8000; op_mode = 3'b011; op_amt = 5'd2;
      @(negedge clk);
      start1 = 1'b0;
      tests++; if (busy1 !== 1'b1 || done1 !== 1'b0) begin
         fails++; $display("FAIL b2b_no_gap: got busy=%b done=%b want busy=1 done=0", busy1, done1);
      end
      wait_done(1'b0, 1, ed, bc);
      e = sb.pop_front();
      tests++; if (sout1 !== e.s || carry1 !== e.c) begin
         fails++; $display("FAIL b2b_second: got %h/%b want %h/%b", sout1, carry1, e.s, e.c);
      end
      tests++; if (ed !== e.edges) begin fails++; $display("FAIL b2b_latency: got %0d want %0d", ed, e.edges); end
   endtask

   task automatic test_random;
      exp_t got, e;
      bit          sel;
      logic [15:0] a;
      logic [2:0]  m;
      logic [4:0]  n;
      for (int i = 0; i < 24; i++) begin
         sel = i[0];
         a   = 16'($urandom);
         m   = 3'($urandom_range(0, 7));
         n   = 5'($urandom_range(0, 31));
         sb.push_back(model(sel, a, m, n));
         run_op(sel, a, m, n, got);
         e = sb.pop_front();
         tests++; if (got.s !== e.s || got.c !== e.c || got.edges !== e.edges) begin
            fails++;
            $display("FAIL rand%0d (sel=%0d in=%h mode=%0d amt=%0d): got %h/%b/%0d want %h/%b/%0d",
                     i, sel, a, m, n, got.s, got.c, got.edges, e.s, e.c, e.edges);
         end
      end
   endtask

   initial begin
      reset = 1'b0; start1 = 1'b0; start4 = 1'b0;
      op_in = '0; op_mode = '0; op_amt = '0;
      test_reset();
      test_lsl();
      test_asr();
      test_ror();
      test_pass();
      test_step4();
      test_ignore_start();
      test_reset_abort();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
